// File: rtl/rs232_pkg.sv
// ---------------------------------------------------------------------------
// rs232_pkg
// Shared definitions for the RS232 transmit path.
//   txState_t     : transmit-feeder state encoding (3-bit)
//   defaultDepth  : default FIFO depth in bytes
//   defaultAw     : log2(defaultDepth)
//   bitTime       : clocks per serial bit, shared with the transmitter
// ---------------------------------------------------------------------------
package rs232_pkg;

  localparam int defaultDepth = 16;
  localparam int defaultAw    = 4;

  // 125 MHz system clock / 115200 baud, rounded.
  localparam int bitTime = 1085;

  // GAPWAIT is the post-ready idle-gap state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    HOLD    = 3'd2,
    BUSY    = 3'd3,
    GAPWAIT = 3'd4
  } txState_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// ---------------------------------------------------------------------------
// tx_fifo_mem
// DEPTH x 8 byte storage for the transmit FIFO. Synchronous write,
// combinational read.
// Ports:
//   clock   in   system clock
//   wrEn    in   write enable
//   wrIdx   in   write index
//   wrData  in   byte to store
//   rdIdx   in   read index
//   rdData  out  byte at rdIdx (combinational)
// ---------------------------------------------------------------------------
module tx_fifo_mem
  import rs232_pkg::*;
#(
  parameter int DEPTH = defaultDepth,
  parameter int AW    = defaultAw
) (
  input  logic          clock,
  input  logic          wrEn,
  input  logic [AW-1:0] wrIdx,
  input  logic [7:0]    wrData,
  input  logic [AW-1:0] rdIdx,
  output logic [7:0]    rdData
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wrEn) begin
      mem[wrIdx] <= wrData;
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/rs232_tx_fifo.sv
// ---------------------------------------------------------------------------
// rs232_tx_fifo
// Transmit-side byte FIFO in front of the RS232 transmitter. The CPU pushes
// characters at bus speed; a small state machine hands them one at a time to
// the transmitter's single-character write strobe, waiting on its ready flag.
//
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-low reset
//   push      in   CPU write strobe, one character per asserted cycle
//   pushData  in   character to enqueue
//   flush     in   synchronous clear of queue contents and overflow
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  queued characters, 0..DEPTH
//   overflow  out  sticky, set when a push is dropped
//   txReady   in   transmitter idle
//   writeTx   out  one-cycle registered strobe to the transmitter
//   txChar    out  registered character, valid while writeTx=1
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for data and txReady; pops head on the decision edge
// SEND    | writeTx high for this cycle only
// HOLD    | one cycle ignoring txReady (it drops one cycle after load)
// BUSY    | waiting for txReady to return
// GAPWAIT | GAP extra idle clocks before the next character
// ---------------------------------------------------------------------------
module rs232_tx_fifo
  import rs232_pkg::*;
#(
  parameter int DEPTH = defaultDepth,
  parameter int AW    = defaultAw,
  parameter int GAP   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  pushData,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        overflow,
  input  logic        txReady,
  output logic        writeTx,
  output logic [7:0]  txChar
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] gapLoad = (GAP > 0) ? GW'(GAP - 1) : '0;

  logic [AW:0]   wrPtr;
  logic [AW:0]   rdPtr;
  logic [AW:0]   countInt;
  logic          fullInt;
  logic          emptyInt;
  logic          overflowReg;
  logic          pushOk;
  logic          pop;
  logic [7:0]    rdData;

  txState_t      state;
  txState_t      stateNext;
  logic          writeTxReg;
  logic          writeTxNext;
  logic [7:0]    txCharReg;
  logic [7:0]    txCharNext;
  logic [GW-1:0] gapCnt;
  logic [GW-1:0] gapCntNext;

  // Extra pointer bit distinguishes full from empty; count is the modular
  // difference.
  assign countInt = wrPtr - rdPtr;
  assign fullInt  = (countInt == (AW+1)'(DEPTH));
  assign emptyInt = (countInt == '0);

  // Flush wins over a same-cycle push; full is the pre-edge value, so a
  // push into a full queue is dropped even if a pop happens this edge.
  assign pushOk = push && !fullInt && !flush;

  tx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) uMem (
    .clock  (clock),
    .wrEn   (pushOk),
    .wrIdx  (wrPtr[AW-1:0]),
    .wrData (pushData),
    .rdIdx  (rdPtr[AW-1:0]),
    .rdData (rdData)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      overflowReg <= 1'b0;
    end else if (flush) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (push && fullInt) begin
        overflowReg <= 1'b1;
      end
      if (pushOk) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      writeTxReg <= 1'b0;
      txCharReg  <= 8'h00;
      gapCnt     <= '0;
    end else begin
      state      <= stateNext;
      writeTxReg <= writeTxNext;
      txCharReg  <= txCharNext;
      gapCnt     <= gapCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    writeTxNext = 1'b0;
    txCharNext  = txCharReg;
    gapCntNext  = gapCnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!emptyInt && txReady) begin
          pop         = 1'b1;
          txCharNext  = rdData;
          writeTxNext = 1'b1;
          stateNext   = SEND;
        end
      end
      SEND: begin
        stateNext = HOLD;
      end
      HOLD: begin
        stateNext = BUSY;
      end
      BUSY: begin
        if (txReady) begin
          if (GAP > 0) begin
            stateNext  = GAPWAIT;
            gapCntNext = gapLoad;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      GAPWAIT: begin
        if (gapCnt == '0) begin
          stateNext = IDLE;
        end else begin
          gapCntNext = gapCnt - 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign full     = fullInt;
  assign empty    = emptyInt;
  assign count    = countInt;
  assign overflow = overflowReg;
  assign writeTx  = writeTxReg;
  assign txChar   = txCharReg;

endmodule

// File: doc/rs232_tx_fifo.md
Name:
rs232_tx_fifo

Overview:
- Transmit-side buffer that sits directly upstream of the RS232 transmitter in the local I/O device.
- Accepts characters from the CPU write path at bus speed and holds up to DEPTH bytes.
- Feeds them one at a time to the transmitter's single-character write strobe, waiting on its ready flag.
- Removes the CPU's need to poll ready before every character and exposes count/full/overflow status for the read path.

Parameters:
- DEPTH, 16, number of byte entries; power of two.
- AW, 4, log2(DEPTH); pointer index width.
- GAP, 0, extra idle clocks inserted after the transmitter reports ready before the next character is issued (0 = back-to-back).

Ports:
- clock  in  1  system clock, 125 MHz
- reset  in  1  asynchronous, active-low reset
- push  in  1  CPU write strobe; one character per asserted cycle
- pushData  in  8  character to enqueue, sampled when push=1
- flush  in  1  synchronous clear of queue contents and overflow flag
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  AW+1  number of queued characters, 0..DEPTH
- overflow  out  1  sticky; set when a push is dropped
- txReady  in  1  transmitter idle (its bit counter is zero)
- writeTx  out  1  one-cycle registered strobe to the transmitter
- txChar  out  8  registered character, valid while writeTx=1; holds its value otherwise

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers and count are 0; state is IDLE.
  - writeTx=0, txChar=0, overflow=0, empty=1, full=0.
  - A reset in the middle of an operation discards queued data and any pending strobe.
- Storage:
  - Circular buffer with AW+1-bit read and write pointers; count = wr-rd, modulo 2^(AW+1).
  - Pointers wrap naturally from DEPTH-1 to 0.
- Push:
  - Accepted when push=1 and full=0, evaluated on pre-edge state.
  - A push while full is dropped and sets overflow, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: both take effect and count is unchanged.
- Flush:
  - Clears the pointers and overflow at the edge; flush wins over a same-cycle push.
  - That dropped push does not set overflow.
  - A strobe already in SEND still completes.
  - An in-flight transmitter character is not aborted.
- State machine, all outputs registered:
  - IDLE: if empty=0 and txReady=1, pop the head into txChar, set writeTx=1 and go to SEND.
  - SEND: writeTx=1 for exactly this cycle. Next state is HOLD, and writeTx returns to 0.
  - HOLD: one cycle with txReady ignored, because the transmitter's ready drops one cycle after it is loaded. Next state is BUSY.
  - BUSY: wait for txReady=1. Then go to GAP if GAP>0, otherwise to IDLE.
  - GAP: count GAP clocks, then go to IDLE.
- Latency:
  - From a push into an empty queue with txReady=1, writeTx is asserted 2 cycles later: push edge, then IDLE decision edge.
  - The minimum spacing between strobes is the transmitter's busy time plus GAP plus 2.
- A flush does not move the state machine; a popped character is already committed.
- full, empty and count reflect post-edge state.

Decomposition:
- Shared package rs232_pkg holds:
  - the state encoding (IDLE, SEND, HOLD, BUSY, GAP), 3-bit;
  - default DEPTH/AW constants;
  - the bitTime constant shared with the transmitter.
- One natural sub-module: tx_fifo_mem, a DEPTH x 8 storage array with synchronous write and combinational read at rd index.
- Pointer, count and state machine logic stay in rs232_tx_fifo.

Test Plan:
- Reset with queue loaded: push 3 bytes, pulse reset low mid-BUSY -> count=0, empty=1, writeTx=0, overflow=0 immediately, with no strobe afterwards.
- Ordering: push 0x41,0x42,0x43 with a transmitter model (ready low 8 cycles after each strobe), GAP=0 -> three writeTx pulses with txChar 0x41,0x42,0x43, each exactly 1 cycle wide, first at push+2.
- Full/overflow: hold txReady=0 and push 17 bytes -> full=1 and count=16 after the 16th, 17th dropped, overflow=1. Then release txReady -> 16 strobes in order, and the 17th byte never appears.
- Pointer wrap: stream 40 bytes through with a random txReady busy time -> output matches input exactly and count returns to 0.
- Flush corners: flush with the same-cycle push while 5 are queued -> count=0 and overflow unchanged. Flush during SEND -> that strobe still occurs and no further strobes follow.
- GAP=4: two bytes queued, txReady returns to 1 at cycle T -> second writeTx at T+6 (GAP 4 + IDLE decision + SEND edge).
